// File: rtl/func_sqrt_ctrl.sv
// func_sqrt_ctrl: sequencer computing y = a*a + sqrt(b) for 8-bit unsigned operands.
// a*a is formed by an 8-step shift-add multiplier; sqrt(b) comes from an external
// multi-cycle unit driven through a start/busy handshake.
// Build option: define FUNC_SQRT_PARALLEL_EN to overlap the multiply with the sqrt wait.
module func_sqrt_ctrl #(
   parameter int unsigned TIMEOUT = 63
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  a_bi,
   input  logic [7:0]  b_bi,
   input  logic        start_i,
   output logic        busy_o,
   output logic [15:0] y_bo,
   output logic        err_o,
   output logic        sqrt_start_o,
   output logic [7:0]  sqrt_x_bo,
   input  logic        sqrt_busy_i,
   input  logic [7:0]  sqrt_y_bi
);

   localparam int unsigned OP_W   = 8;
   localparam int unsigned Y_W    = 16;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_MUL        = 3'd1;
   localparam logic [2:0] S_SQ_START   = 3'd2;
   localparam logic [2:0] S_SQ_WAIT_HI = 3'd3;
   localparam logic [2:0] S_SQ_WAIT_LO = 3'd4;
   localparam logic [2:0] S_ADD        = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [OP_W-1:0]   a_q, a_d;
   logic [OP_W-1:0]   b_q, b_d;
   logic [Y_W-1:0]    prod_q, prod_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [OP_W-1:0]   root_q, root_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic              err_q, err_d;
   logic              sq_start_q, sq_start_d;
`ifdef FUNC_SQRT_PARALLEL_EN
   logic              root_ok_q, root_ok_d;
`endif

   logic [Y_W-1:0]    pp_c;
   logic [WAIT_W-1:0] wait_inc_c;
   logic              wait_expired_c;

   // Partial product for the current multiplier bit and saturating wait-count increment
   always_comb begin
      pp_c           = a_q[cnt_q[2:0]] ? (Y_W'(a_q) << cnt_q[2:0]) : '0;
      wait_inc_c     = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + WAIT_W'(1);
      wait_expired_c = (wait_inc_c == WAIT_W'(TIMEOUT));
   end

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      prod_d     = prod_q;
      cnt_d      = cnt_q;
      wait_d     = wait_q;
      root_d     = root_q;
      y_d        = y_q;
      err_d      = err_q;
      sq_start_d = 1'b0;
`ifdef FUNC_SQRT_PARALLEL_EN
      root_ok_d  = root_ok_q;
      // Multiplier runs alongside the sqrt handshake until 8 steps are done
      if (((state_q == S_SQ_START) || (state_q == S_SQ_WAIT_HI) ||
           (state_q == S_SQ_WAIT_LO)) && !cnt_q[3]) begin
         prod_d = prod_q + pp_c;
         cnt_d  = cnt_q + CNT_W'(1);
      end
`endif

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_d    = a_bi;
               b_d    = b_bi;
               prod_d = '0;
               cnt_d  = '0;
               err_d  = 1'b0;
`ifdef FUNC_SQRT_PARALLEL_EN
               root_ok_d = 1'b0;
               state_d   = S_SQ_START;
`else
               state_d   = S_MUL;
`endif
            end
         end
         S_MUL: begin
            prod_d = prod_q + pp_c;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
               state_d = S_SQ_START;
            end
         end
         S_SQ_START: begin
            wait_d  = '0;
            state_d = S_SQ_WAIT_HI;
         end
         S_SQ_WAIT_HI: begin
            if (sqrt_busy_i) begin
               wait_d  = '0;
               state_d = S_SQ_WAIT_LO;
            end else if (wait_expired_c) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_inc_c;
            end
         end
         S_SQ_WAIT_LO: begin
`ifdef FUNC_SQRT_PARALLEL_EN
            if (root_ok_q || !sqrt_busy_i) begin
               if (!root_ok_q) begin
                  root_d    = sqrt_y_bi;
                  root_ok_d = 1'b1;
               end
               if (cnt_d[3]) begin
                  state_d = S_ADD;
               end
            end else if (wait_expired_c) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_inc_c;
            end
`else
            if (!sqrt_busy_i) begin
               root_d  = sqrt_y_bi;
               state_d = S_ADD;
            end else if (wait_expired_c) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wait_d = wait_inc_c;
            end
`endif
         end
         S_ADD: begin
            y_d     = prod_q + Y_W'(root_q);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      sq_start_d = (state_d == S_SQ_START);
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         prod_q     <= '0;
         cnt_q      <= '0;
         wait_q     <= '0;
         root_q     <= '0;
         y_q        <= '0;
         err_q      <= 1'b0;
         sq_start_q <= 1'b0;
`ifdef FUNC_SQRT_PARALLEL_EN
         root_ok_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         prod_q     <= prod_d;
         cnt_q      <= cnt_d;
         wait_q     <= wait_d;
         root_q     <= root_d;
         y_q        <= y_d;
         err_q      <= err_d;
         sq_start_q <= sq_start_d;
`ifdef FUNC_SQRT_PARALLEL_EN
         root_ok_q  <= root_ok_d;
`endif
      end
   end

   // Output mapping; busy follows the registered state
   always_comb begin
      busy_o       = (state_q != S_IDLE);
      y_bo         = y_q;
      err_o        = err_q;
      sqrt_start_o = sq_start_q;
      sqrt_x_bo    = b_q;
   end

endmodule

// File: tb/tb_func_sqrt_ctrl.sv
// Testbench for func_sqrt_ctrl: behavioural sqrt unit plus a plain-arithmetic
// reference (a*a + floor(sqrt(b))) with randomized operands and sqrt delays.
module tb_func_sqrt_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [7:0]  a_bi = '0;
   logic [7:0]  b_bi = '0;
   logic        start_i = 1'b0;
   logic        busy_o;
   logic [15:0] y_bo;
   logic        err_o;
   logic        sqrt_start_o;
   logic [7:0]  sqrt_x_bo;
   logic        sqrt_busy_i;
   logic [7:0]  sqrt_y_bi;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_pulse = 0;
   logic [7:0]  x_seen = '0;
   int          sm_dly = 0;
   bit          sm_hang = 1'b0;
   int          sm_cnt;
   logic [7:0]  sm_x;
   int unsigned model_y = 0;

   func_sqrt_ctrl #(.TIMEOUT(63)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .a_bi         (a_bi),
      .b_bi         (b_bi),
      .start_i      (start_i),
      .busy_o       (busy_o),
      .y_bo         (y_bo),
      .err_o        (err_o),
      .sqrt_start_o (sqrt_start_o),
      .sqrt_x_bo    (sqrt_x_bo),
      .sqrt_busy_i  (sqrt_busy_i),
      .sqrt_y_bi    (sqrt_y_bi)
   );

   always #5 clk_i = ~clk_i;

   function automatic int unsigned isqrt(input int unsigned x);
      int unsigned r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural sqrt unit: busy rises the cycle after start, stays high sm_dly+1 cycles
   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sqrt_busy_i <= 1'b0;
         sqrt_y_bi   <= '0;
         sm_cnt      <= 0;
         sm_x        <= '0;
      end else if (!sqrt_busy_i) begin
         if (sqrt_start_o && !sm_hang) begin
            sqrt_busy_i <= 1'b1;
            sm_cnt      <= sm_dly;
            sm_x        <= sqrt_x_bo;
         end
      end else if (sm_cnt == 0) begin
         sqrt_busy_i <= 1'b0;
         sqrt_y_bi   <= 8'(isqrt(32'(sm_x)));
      end else begin
         sm_cnt <= sm_cnt - 1;
      end
   end

   // Count sqrt start pulses and remember the operand offered with them
   always @(posedge clk_i) begin
      if (sqrt_start_o) begin
         n_pulse <= n_pulse + 1;
         x_seen  <= sqrt_x_bo;
      end
   end

   // One operation: start, optional stray starts, wait for completion, compare
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int dly,
                         input bit inject, input bit hang);
      int p0;
      int lat;
      int unsigned exp_y;
      int unsigned exp_lat;
      sm_dly  = dly;
      sm_hang = hang;
      p0      = n_pulse;
      lat     = -1;
      a_bi    = a;
      b_bi    = b;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      a_bi    = 8'($urandom);
      b_bi    = 8'($urandom);
      check_val("busy_after_start", 32'(busy_o), 1);
      check_val("err_cleared", 32'(err_o), 0);
      for (int n = 1; n <= 300; n++) begin
         if (inject && (n == 3 || n == 12)) begin
            start_i = 1'b1;
            a_bi    = ~a;
            b_bi    = ~b;
         end else begin
            start_i = 1'b0;
         end
         @(posedge clk_i);
         #1;
         if (!busy_o) begin
            lat = n;
            break;
         end
      end
      start_i = 1'b0;
      check_val("op_done", 32'(busy_o), 0);
      if (hang) begin
         exp_y   = model_y;
         exp_lat = 8 + 1 + 63;
         check_val("err_timeout", 32'(err_o), 1);
      end else begin
         exp_y   = 32'(a) * 32'(a) + isqrt(32'(b));
         exp_lat = 8 + 1 + 1 + 32'(dly + 1) + 1;
         model_y = exp_y;
         check_val("err_ok", 32'(err_o), 0);
      end
      check_val("y", 32'(y_bo), exp_y);
      check_val("sqrt_pulses", 32'(n_pulse - p0), 1);
      check_val("sqrt_x", 32'(x_seen), 32'(b));
`ifndef FUNC_SQRT_PARALLEL_EN
      check_val("latency", 32'(lat), exp_lat);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      check_val("rst_busy", 32'(busy_o), 0);
      check_val("rst_y", 32'(y_bo), 0);
      check_val("rst_err", 32'(err_o), 0);
      check_val("rst_sqrt_start", 32'(sqrt_start_o), 0);
      check_val("rst_sqrt_x", 32'(sqrt_x_bo), 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);

      run_op(8'd3, 8'd16, 2, 1'b0, 1'b0);
      run_op(8'd255, 8'd255, 0, 1'b0, 1'b0);
      run_op(8'd0, 8'd0, 1, 1'b0, 1'b0);
      run_op(8'd1, 8'd1, 3, 1'b0, 1'b0);
      run_op(8'd10, 8'd50, 5, 1'b1, 1'b0);

      for (int i = 0; i < 20; i++) begin
         run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 8)), 1'b0, 1'b0);
      end

      // Sqrt unit never answers: abort on timeout, then recover
      run_op(8'd7, 8'd7, 0, 1'b0, 1'b1);
      run_op(8'd4, 8'd25, 1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of the low-busy wait
      sm_dly  = 20;
      sm_hang = 1'b0;
      a_bi    = 8'd5;
      b_bi    = 8'd100;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      repeat (13) @(posedge clk_i);
      #4;
      check_val("pre_rst_busy", 32'(busy_o), 1);
      rst_i = 1'b0;
      #1;
      check_val("arst_busy", 32'(busy_o), 0);
      check_val("arst_y", 32'(y_bo), 0);
      check_val("arst_err", 32'(err_o), 0);
      check_val("arst_sqrt_start", 32'(sqrt_start_o), 0);
      check_val("arst_sqrt_x", 32'(sqrt_x_bo), 0);
      model_y = 0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      run_op(8'd2, 8'd9, 2, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
